// File: rtl/game_sequencer_pkg.sv
// Shared game definitions: state encoding, game timing constants, spawn periods.
package game_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      PLAY  = 2'd2,
      DONE  = 2'd3
   } game_state_t;

   localparam int MAX_GAMETIME = 60;
   localparam int READY_SECS   = 3;

   // Seconds between spawns, indexed by difficulty (3 aliases hard)
   localparam logic [3:0][2:0] SPAWN_PERIOD = {3'd1, 3'd1, 3'd3, 3'd5};

   function automatic logic [5:0] clamp_gametime(input logic [5:0] gt);
      logic [5:0] r;
      if (gt == 6'd0)
         r = 6'd1;
      else if (gt > 6'(MAX_GAMETIME))
         r = 6'(MAX_GAMETIME);
      else
         r = gt;
      return r;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game front panel and the sequencer.
interface game_sequencer_if;
   import game_sequencer_pkg::*;

   logic        start_pulse;
   logic        abort;
   logic [5:0]  gametime;
   logic [1:0]  difficulty;
   game_state_t state;
   logic        gamestart;
   logic        gameend;
   logic [5:0]  timeleft;
   logic        spawn;
   logic        clear_score;

   modport master (
      output start_pulse, abort, gametime, difficulty,
      input  state, gamestart, gameend, timeleft, spawn, clear_score
   );

   modport slave (
      input  start_pulse, abort, gametime, difficulty,
      output state, gamestart, gameend, timeleft, spawn, clear_score
   );

endinterface

// File: rtl/game_sequencer_sec_prescaler.sv
// Game-second prescaler: sec_tick is high on the last count of each second.
// Combinational tick from registered count; restart zeroes the count on the next edge.
module sec_prescaler #(
   parameter int TICKS_PER_SEC = 100000000
) (
   input  logic CLK100MHZ,
   input  logic RST_BTN,
   input  logic restart,
   output logic sec_tick
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   assign sec_tick = (cnt == LAST);

   always_ff @(posedge CLK100MHZ or posedge RST_BTN) begin
      if (RST_BTN)
         cnt <= '0;
      else if (restart || sec_tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/game_sequencer.sv
// Whack-a-mole game sequencer: IDLE -> READY countdown -> PLAY (timed, spawns) -> DONE.
// All outputs registered, one cycle after the causing input or sec_tick; no backpressure.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100000000
) (
   input  logic            CLK100MHZ,
   input  logic            RST_BTN,
   game_sequencer_if.slave gs
);

   game_state_t state_q, state_d;
   logic [5:0]  timeleft_q, timeleft_d;
   logic [5:0]  gt_lat_q, gt_lat_d;
   logic [1:0]  diff_lat_q, diff_lat_d;
   logic [2:0]  spawn_cnt_q, spawn_cnt_d;
   logic        spawn_q, spawn_d;
   logic        clear_q, clear_d;
   logic        gamestart_q, gameend_q;
   logic        sec_tick;
   logic        presc_restart;
   logic [2:0]  period;

   assign period        = SPAWN_PERIOD[diff_lat_q];
   assign presc_restart = (state_d != state_q);

   sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_prescaler (
      .CLK100MHZ (CLK100MHZ),
      .RST_BTN   (RST_BTN),
      .restart   (presc_restart),
      .sec_tick  (sec_tick)
   );

   always_comb begin
      state_d     = state_q;
      timeleft_d  = timeleft_q;
      gt_lat_d    = gt_lat_q;
      diff_lat_d  = diff_lat_q;
      spawn_cnt_d = spawn_cnt_q;
      spawn_d     = 1'b0;
      clear_d     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (gs.start_pulse) begin
               state_d    = READY;
               gt_lat_d   = clamp_gametime(gs.gametime);
               diff_lat_d = gs.difficulty;
               timeleft_d = 6'(READY_SECS);
               clear_d    = 1'b1;
            end
         end
         READY: begin
            if (sec_tick) begin
               if (timeleft_q == 6'd1) begin
                  state_d     = PLAY;
                  timeleft_d  = gt_lat_q;
                  spawn_d     = 1'b1;
                  spawn_cnt_d = '0;
               end else begin
                  timeleft_d = timeleft_q - 6'd1;
               end
            end
         end
         PLAY: begin
            // Abort wins over a coincident tick, so timeleft freezes at its current value
            if (gs.abort) begin
               state_d = DONE;
            end else if (sec_tick) begin
               timeleft_d = timeleft_q - 6'd1;
               if (timeleft_q == 6'd1) begin
                  state_d = DONE;
               end else if (spawn_cnt_q + 3'd1 == period) begin
                  spawn_d     = 1'b1;
                  spawn_cnt_d = '0;
               end else begin
                  spawn_cnt_d = spawn_cnt_q + 3'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK100MHZ or posedge RST_BTN) begin
      if (RST_BTN) begin
         state_q     <= IDLE;
         timeleft_q  <= '0;
         gt_lat_q    <= '0;
         diff_lat_q  <= '0;
         spawn_cnt_q <= '0;
         spawn_q     <= 1'b0;
         clear_q     <= 1'b0;
         gamestart_q <= 1'b0;
         gameend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timeleft_q  <= timeleft_d;
         gt_lat_q    <= gt_lat_d;
         diff_lat_q  <= diff_lat_d;
         spawn_cnt_q <= spawn_cnt_d;
         spawn_q     <= spawn_d;
         clear_q     <= clear_d;
         gamestart_q <= (state_d == PLAY);
         gameend_q   <= (state_d == DONE);
      end
   end

   assign gs.state       = state_q;
   assign gs.timeleft    = timeleft_q;
   assign gs.spawn       = spawn_q;
   assign gs.clear_score = clear_q;
   assign gs.gamestart   = gamestart_q;
   assign gs.gameend     = gameend_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer at 10 ticks per game second; spawns scoreboarded by PLAY cycle.
module tb_game_sequencer;
   import game_sequencer_pkg::*;

   logic CLK100MHZ = 1'b0;
   logic RST_BTN   = 1'b1;

   always #5 CLK100MHZ = ~CLK100MHZ;

   game_sequencer_if gs();

   game_sequencer #(.TICKS_PER_SEC(10)) dut (
      .CLK100MHZ (CLK100MHZ),
      .RST_BTN   (RST_BTN),
      .gs        (gs)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int exp_spawn[$];
   int obs_spawn[$];
   int obs_clr[$];
   int obs_tl[$];
   int play_cyc   = 0;
   int ready_cyc  = 0;
   int play_len   = -1;
   int ready_len  = -1;
   logic [1:0] prev_state = 2'd0;
   logic [5:0] prev_tl    = 6'd0;

   // Monitor: samples 1 time unit after each rising edge and logs events by cycle index
   always @(posedge CLK100MHZ) begin
      #1;
      if (gs.state == 2'd1) begin
         ready_cyc = (prev_state == 2'd1) ? ready_cyc + 1 : 0;
         if (prev_state != 2'd1 || gs.timeleft != prev_tl) obs_tl.push_back(int'(gs.timeleft));
      end
      if (gs.state == 2'd2) begin
         if (prev_state != 2'd2) begin
            play_cyc = 0;
            if (prev_state == 2'd1) ready_len = ready_cyc + 1;
         end else begin
            play_cyc = play_cyc + 1;
         end
      end
      if (gs.state == 2'd3 && prev_state == 2'd2) play_len = play_cyc + 1;
      if (gs.spawn) obs_spawn.push_back((gs.state == 2'd2) ? play_cyc : -1);
      if (gs.clear_score) obs_clr.push_back((gs.state == 2'd1) ? ready_cyc : -1);
      prev_state = gs.state;
      prev_tl    = gs.timeleft;
   end

   task automatic sb_flush();
      exp_spawn.delete();
      obs_spawn.delete();
      obs_clr.delete();
      obs_tl.delete();
      play_len  = -1;
      ready_len = -1;
   endtask

   task automatic start_game(input logic [5:0] gt, input logic [1:0] df);
      @(negedge CLK100MHZ);
      gs.gametime    = gt;
      gs.difficulty  = df;
      gs.start_pulse = 1'b1;
      @(negedge CLK100MHZ);
      gs.start_pulse = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (gs.state == s) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK100MHZ);
      end
   endtask

   task automatic test_reset();
      RST_BTN = 1'b1;
      repeat (3) @(negedge CLK100MHZ);
      n_checks++; if (gs.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", gs.state); end
      n_checks++; if (gs.timeleft !== 6'd0) begin n_fail++; $display("FAIL reset_timeleft: got %0d required 0", gs.timeleft); end
      n_checks++; if (gs.spawn !== 1'b0) begin n_fail++; $display("FAIL reset_spawn: got %b required 0", gs.spawn); end
      n_checks++; if (gs.clear_score !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %b required 0", gs.clear_score); end
      n_checks++; if (gs.gamestart !== 1'b0 || gs.gameend !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: gamestart=%b gameend=%b required 0 0", gs.gamestart, gs.gameend);
      end
      RST_BTN = 1'b0;
      gs.abort = 1'b1;
      repeat (3) @(negedge CLK100MHZ);
      gs.abort = 1'b0;
      n_checks++; if (gs.state !== 2'd0) begin n_fail++; $display("FAIL idle_abort_ignored: state %0d required 0", gs.state); end
   endtask

   task automatic test_basic();
      bit ok;
      int e, o;
      sb_flush();
      exp_spawn.push_back(0);
      start_game(6'd5, 2'd0);
      wait_state(2'd3, 200, ok);
      repeat (3) @(negedge CLK100MHZ);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done_timeout: state %0d required 3", gs.state); end
      n_checks++; if (ready_len !== 30) begin n_fail++; $display("FAIL basic_ready_len: got %0d required 30", ready_len); end
      n_checks++; if (play_len !== 50) begin n_fail++; $display("FAIL basic_play_len: got %0d required 50", play_len); end
      n_checks++; if (gs.timeleft !== 6'd0) begin n_fail++; $display("FAIL basic_done_timeleft: got %0d required 0", gs.timeleft); end
      n_checks++; if (gs.gameend !== 1'b1 || gs.gamestart !== 1'b0) begin
         n_fail++; $display("FAIL basic_done_flags: gameend=%b gamestart=%b required 1 0", gs.gameend, gs.gamestart);
      end
      n_checks++; if (obs_clr.size() !== 1 || obs_clr[0] !== 0) begin
         n_fail++; $display("FAIL basic_clear: %0d pulses, required 1 at READY cycle 0", obs_clr.size());
      end
      for (int v = 3; v >= 1; v--) begin
         if (obs_tl.size() > 0) o = obs_tl.pop_front(); else o = -99;
         n_checks++; if (o !== v) begin n_fail++; $display("FAIL basic_ready_count: got %0d required %0d", o, v); end
      end
      n_checks++; if (obs_tl.size() !== 0) begin n_fail++; $display("FAIL basic_ready_extra: %0d extra values required 0", obs_tl.size()); end
      while (exp_spawn.size() > 0 || obs_spawn.size() > 0) begin
         if (exp_spawn.size() > 0) e = exp_spawn.pop_front(); else e = -99;
         if (obs_spawn.size() > 0) o = obs_spawn.pop_front(); else o = -99;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_spawn: play cycle %0d required %0d", o, e); end
      end
   endtask

   task automatic test_hard_latch();
      bit ok;
      int e, o;
      sb_flush();
      for (int i = 0; i < 7; i++) exp_spawn.push_back(i * 10);
      start_game(6'd7, 2'd2);
      gs.gametime   = 6'd2;
      gs.difficulty = 2'd0;
      wait_state(2'd3, 300, ok);
      repeat (3) @(negedge CLK100MHZ);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hard_done_timeout: state %0d required 3", gs.state); end
      n_checks++; if (play_len !== 70) begin n_fail++; $display("FAIL hard_play_len: got %0d required 70", play_len); end
      n_checks++; if (obs_clr.size() !== 1 || obs_clr[0] !== 0) begin
         n_fail++; $display("FAIL hard_clear: %0d pulses, required 1 at READY cycle 0", obs_clr.size());
      end
      while (exp_spawn.size() > 0 || obs_spawn.size() > 0) begin
         if (exp_spawn.size() > 0) e = exp_spawn.pop_front(); else e = -99;
         if (obs_spawn.size() > 0) o = obs_spawn.pop_front(); else o = -99;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL hard_spawn: play cycle %0d required %0d", o, e); end
      end
   endtask

   task automatic test_clamp();
      bit ok;
      int e, o;
      sb_flush();
      exp_spawn.push_back(0);
      start_game(6'd0, 2'd1);
      wait_state(2'd3, 200, ok);
      repeat (3) @(negedge CLK100MHZ);
      n_checks++; if (play_len !== 10) begin n_fail++; $display("FAIL clamp_zero_len: got %0d required 10", play_len); end
      exp_spawn.push_back(0);
      start_game(6'd63, 2'd0);
      wait_state(2'd2, 100, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL clamp_play_timeout: state %0d required 2", gs.state); end
      n_checks++; if (gs.timeleft !== 6'd60) begin n_fail++; $display("FAIL clamp_max_load: got %0d required 60", gs.timeleft); end
      n_checks++; if (gs.gamestart !== 1'b1 || gs.gameend !== 1'b0) begin
         n_fail++; $display("FAIL play_flags: gamestart=%b gameend=%b required 1 0", gs.gamestart, gs.gameend);
      end
      gs.abort = 1'b1;
      @(negedge CLK100MHZ);
      gs.abort = 1'b0;
      n_checks++; if (gs.state !== 2'd3 || gs.timeleft !== 6'd60) begin
         n_fail++; $display("FAIL clamp_abort: state %0d timeleft %0d required 3 60", gs.state, gs.timeleft);
      end
      while (exp_spawn.size() > 0 || obs_spawn.size() > 0) begin
         if (exp_spawn.size() > 0) e = exp_spawn.pop_front(); else e = -99;
         if (obs_spawn.size() > 0) o = obs_spawn.pop_front(); else o = -99;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL clamp_spawn: play cycle %0d required %0d", o, e); end
      end
   endtask

   task automatic test_abort();
      bit ok;
      int e, o;
      sb_flush();
      exp_spawn.push_back(0);
      exp_spawn.push_back(10);
      exp_spawn.push_back(20);
      start_game(6'd6, 2'd2);
      wait_state(2'd2, 100, ok);
      repeat (29) @(negedge CLK100MHZ);
      n_checks++; if (gs.timeleft !== 6'd4) begin n_fail++; $display("FAIL abort_pre_timeleft: got %0d required 4", gs.timeleft); end
      gs.abort = 1'b1;
      @(negedge CLK100MHZ);
      n_checks++; if (gs.state !== 2'd3) begin n_fail++; $display("FAIL abort_state: got %0d required 3", gs.state); end
      n_checks++; if (gs.timeleft !== 6'd4) begin n_fail++; $display("FAIL abort_timeleft: got %0d required 4", gs.timeleft); end
      n_checks++; if (gs.spawn !== 1'b0) begin n_fail++; $display("FAIL abort_spawn: got %b required 0", gs.spawn); end
      repeat (12) @(negedge CLK100MHZ);
      gs.abort = 1'b0;
      n_checks++; if (gs.state !== 2'd3 || gs.timeleft !== 6'd4) begin
         n_fail++; $display("FAIL done_hold: state %0d timeleft %0d required 3 4", gs.state, gs.timeleft);
      end
      n_checks++; if (play_len !== 30) begin n_fail++; $display("FAIL abort_play_len: got %0d required 30", play_len); end
      while (exp_spawn.size() > 0 || obs_spawn.size() > 0) begin
         if (exp_spawn.size() > 0) e = exp_spawn.pop_front(); else e = -99;
         if (obs_spawn.size() > 0) o = obs_spawn.pop_front(); else o = -99;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL abort_spawn_seq: play cycle %0d required %0d", o, e); end
      end
   endtask

   task automatic test_restart();
      bit ok;
      int e, o;
      sb_flush();
      exp_spawn.push_back(0);
      start_game(6'd4, 2'd0);
      wait_state(2'd2, 100, ok);
      repeat (5) @(negedge CLK100MHZ);
      gs.gametime    = 6'd20;
      gs.difficulty  = 2'd1;
      gs.start_pulse = 1'b1;
      @(negedge CLK100MHZ);
      gs.start_pulse = 1'b0;
      n_checks++; if (gs.state !== 2'd2) begin n_fail++; $display("FAIL play_start_ignored: state %0d required 2", gs.state); end
      wait_state(2'd3, 200, ok);
      repeat (2) @(negedge CLK100MHZ);
      n_checks++; if (play_len !== 40) begin n_fail++; $display("FAIL restart_first_len: got %0d required 40", play_len); end
      n_checks++; if (obs_clr.size() !== 1) begin n_fail++; $display("FAIL restart_first_clear: %0d pulses required 1", obs_clr.size()); end
      obs_clr.delete();
      exp_spawn.push_back(0);
      exp_spawn.push_back(30);
      exp_spawn.push_back(60);
      start_game(6'd7, 2'd1);
      wait_state(2'd3, 300, ok);
      repeat (2) @(negedge CLK100MHZ);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL restart_done_timeout: state %0d required 3", gs.state); end
      n_checks++; if (obs_clr.size() !== 1 || obs_clr[0] !== 0) begin
         n_fail++; $display("FAIL restart_clear: %0d pulses, required 1 at READY cycle 0", obs_clr.size());
      end
      n_checks++; if (play_len !== 70) begin n_fail++; $display("FAIL restart_play_len: got %0d required 70", play_len); end
      while (exp_spawn.size() > 0 || obs_spawn.size() > 0) begin
         if (exp_spawn.size() > 0) e = exp_spawn.pop_front(); else e = -99;
         if (obs_spawn.size() > 0) o = obs_spawn.pop_front(); else o = -99;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL restart_spawn: play cycle %0d required %0d", o, e); end
      end
   endtask

   task automatic test_reset_midgame();
      bit ok;
      int e, o;
      sb_flush();
      exp_spawn.push_back(0);
      exp_spawn.push_back(10);
      start_game(6'd10, 2'd2);
      wait_state(2'd2, 100, ok);
      repeat (15) @(negedge CLK100MHZ);
      #2 RST_BTN = 1'b1;
      #1;
      n_checks++; if (gs.state !== 2'd0 || gs.timeleft !== 6'd0) begin
         n_fail++; $display("FAIL midreset_state: state %0d timeleft %0d required 0 0", gs.state, gs.timeleft);
      end
      n_checks++; if (gs.spawn !== 1'b0 || gs.clear_score !== 1'b0 || gs.gamestart !== 1'b0 || gs.gameend !== 1'b0) begin
         n_fail++; $display("FAIL midreset_outputs: spawn=%b clear=%b gamestart=%b gameend=%b required all 0",
                            gs.spawn, gs.clear_score, gs.gamestart, gs.gameend);
      end
      while (exp_spawn.size() > 0 || obs_spawn.size() > 0) begin
         if (exp_spawn.size() > 0) e = exp_spawn.pop_front(); else e = -99;
         if (obs_spawn.size() > 0) o = obs_spawn.pop_front(); else o = -99;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL midreset_pre_spawn: play cycle %0d required %0d", o, e); end
      end
      obs_clr.delete();
      @(negedge CLK100MHZ);
      RST_BTN = 1'b0;
      repeat (60) @(negedge CLK100MHZ);
      n_checks++; if (obs_spawn.size() !== 0 || obs_clr.size() !== 0) begin
         n_fail++; $display("FAIL midreset_quiet: %0d spawns %0d clears required 0 0", obs_spawn.size(), obs_clr.size());
      end
      n_checks++; if (gs.state !== 2'd0) begin n_fail++; $display("FAIL midreset_idle: state %0d required 0", gs.state); end
   endtask

   initial begin
      gs.start_pulse = 1'b0;
      gs.abort       = 1'b0;
      gs.gametime    = 6'd0;
      gs.difficulty  = 2'd0;
      test_reset();
      test_basic();
      test_hard_latch();
      test_clamp();
      test_abort();
      test_restart();
      test_reset_midgame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
